mult_unit: RTL and testbench

MULT_UNIT -- requirements
Module: mult_unit

---
 rtl/mult_unit_if.sv | 14 +
 rtl/mult_unit.sv | 110 +++++++++++
 tb/tb_mult_unit.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mult_unit_if.sv
// Request/result bundle between a control unit (master) and the multiply unit (slave).
interface mult_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    modport master (output start, op, a, b, input hi, lo, busy, done);
    modport slave  (input start, op, a, b, output hi, lo, busy, done);
endinterface

// File: rtl/mult_unit.sv
// Sequential 32x32 multiplier (radix-2 shift-add, 32 iterations) with MIPS-style HI/LO
// registers and MTHI/MTLO writes; signed MULT is done on magnitudes with a final negate.
module mult_unit (
    input  logic         clk,
    input  logic         rst,
    mult_unit_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [63:0] acc_q, acc_d;
    logic [63:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        sign_q, sign_d;

    logic [31:0] abs_a, abs_b;
    logic [63:0] result;

    // Unsigned magnitude: 0x80000000 maps to itself, which is the exact value of |-2^31|.
    assign abs_a  = bus.a[31] ? (~bus.a + 32'd1) : bus.a;
    assign abs_b  = bus.b[31] ? (~bus.b + 32'd1) : bus.b;
    assign result = sign_q ? (~acc_q + 64'd1) : acc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            sign_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            sign_q   <= sign_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        sign_d   = sign_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        2'b00: begin
                            mcand_d  = {32'd0, bus.a};
                            mplier_d = bus.b;
                            sign_d   = 1'b0;
                            acc_d    = '0;
                            count_d  = '0;
                            state_d  = CALC;
                        end
                        2'b01: begin
                            mcand_d  = {32'd0, abs_a};
                            mplier_d = abs_b;
                            sign_d   = bus.a[31] ^ bus.b[31];
                            acc_d    = '0;
                            count_d  = '0;
                            state_d  = CALC;
                        end
                        2'b10: hi_d = bus.a;
                        2'b11: lo_d = bus.a;
                    endcase
                end
            end
            CALC: begin
                // Multiplicand walks left while the multiplier is consumed LSB-first.
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = {mcand_q[62:0], 1'b0};
                mplier_d = {1'b0, mplier_q[31:1]};
                count_d  = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                hi_d    = result[63:32];
                lo_d    = result[31:0];
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = (state_q == CALC) || (state_q == FIX);
    assign bus.done = (state_q == DONE);
endmodule

// File: tb/tb_mult_unit.sv
// Randomised scoreboard bench for mult_unit: driver queues expected products from an
// arithmetic reference, a negedge monitor checks results, latency and HI/LO stability.
module tb_mult_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_unit_if bus ();
    mult_unit dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          busy_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        if (op == 2'b01) begin
            sa = $signed(a);
            sb = $signed(b);
            return sa * sb;
        end
        ua = a;
        ub = b;
        return ua * ub;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse, checks HI/LO never move while busy.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) busy_cnt = 0;
            if (bus.busy) begin
                busy_cnt++;
                check("hold_during_busy", {bus.hi, bus.lo}, {model_hi, model_lo});
            end
            if (bus.done) begin
                done_cnt++;
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("product", {bus.hi, bus.lo}, {e.hi, e.lo});
                    check("done_cycle", 64'(cyc), 64'(e.cyc));
                    check("busy_cycles", 64'(busy_cnt), 64'd33);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic issue_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             output logic [63:0] p);
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        p    = ref_mul(op, a, b);
        e.hi = p[63:32];
        e.lo = p[31:0];
        e.cyc = cyc + 1 + 33;
        sb_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    task automatic wait_done(input logic [63:0] p);
        bit got = 0;
        for (int i = 0; i < 80; i++) begin
            if (bus.done) begin
                got = 1;
                break;
            end
            @(negedge clk);
            bus.a = $urandom;
            bus.b = $urandom;
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: got no done within 80 cycles expected one (cycle %0d)", cyc);
        end
        model_hi = p[63:32];
        model_lo = p[31:0];
    endtask

    task automatic run_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        issue_mul(op, a, b, p);
        wait_done(p);
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h", op, a, b, bus.hi, bus.lo);
    endtask

    task automatic move_to(input logic is_lo, input logic [31:0] v);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = is_lo ? 2'b11 : 2'b10;
        bus.a     = v;
        check("mt_busy_before", {63'd0, bus.busy}, 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        if (is_lo) begin
            model_lo = v;
            check("mtlo_value", {32'd0, bus.lo}, {32'd0, v});
        end else begin
            model_hi = v;
            check("mthi_value", {32'd0, bus.hi}, {32'd0, v});
        end
        check("mt_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
        $display("%s a=%h -> hi=%h lo=%h", is_lo ? "MTLO" : "MTHI", v, bus.hi, bus.lo);
    endtask

    initial begin
        logic [63:0] p;
        int          d0;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        rst = 1'b1;
        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {bus.hi, bus.lo}, 64'd0);
        check("reset_flags", {62'd0, bus.busy, bus.done}, 64'd0);
        rst = 1'b0;

        run_mul(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("multu_max", {bus.hi, bus.lo}, 64'hFFFFFFFE_00000001);
        run_mul(2'b01, 32'hFFFFFFFD, 32'h00000007);
        check("mult_neg3x7", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFEB);
        // Back-to-back: next start issued on the first IDLE cycle after DONE.
        run_mul(2'b01, 32'h80000000, 32'h80000000);
        check("mult_minmin", {bus.hi, bus.lo}, 64'h40000000_00000000);

        move_to(1'b0, 32'h12345678);
        move_to(1'b1, 32'h9ABCDEF0);
        check("mt_pair", {bus.hi, bus.lo}, 64'h12345678_9ABCDEF0);

        // Start re-asserted mid-CALC must be ignored.
        d0 = done_cnt;
        issue_mul(2'b00, 32'd5, 32'd6, p);
        repeat (9) @(negedge clk);
        bus.start = 1'b1;
        bus.op = 2'b00;
        bus.a = 32'd7;
        bus.b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(p);
        check("ignored_start_result", {bus.hi, bus.lo}, 64'd30);
        repeat (45) @(negedge clk);
        check("single_done_pulse", 64'(done_cnt - d0), 64'd1);
        $display("MULTU 5x6 with stray start -> hi=%h lo=%h", bus.hi, bus.lo);

        // Abort by reset in the middle of CALC.
        move_to(1'b0, 32'h0000AAAA);
        move_to(1'b1, 32'h00005555);
        d0 = done_cnt;
        issue_mul(2'b00, $urandom, $urandom, p);
        repeat (14) @(negedge clk);
        #2;
        rst = 1'b1;
        model_hi = '0;
        model_lo = '0;
        void'(sb_q.pop_back());
        #1;
        check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        check("abort_flags", {62'd0, bus.busy, bus.done}, 64'd0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = 2'b00;
        bus.a = 32'd9;
        bus.b = 32'd9;
        repeat (3) @(negedge clk);
        bus.start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("start_during_reset", {62'd0, bus.busy, bus.done}, 64'd0);
        check("no_done_after_abort", 64'(done_cnt - d0), 64'd0);
        $display("reset abort -> hi=%h lo=%h", bus.hi, bus.lo);
        run_mul(2'b00, 32'd2, 32'd3);
        check("after_abort", {bus.hi, bus.lo}, 64'd6);

        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 5) == 0) ra = '0;
            if ($urandom_range(0, 5) == 0) rb = 32'h80000000;
            if (i % 8 == 7) move_to(1'($urandom_range(0, 1)), $urandom);
            run_mul(rop, ra, rb);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
